zcode_event_counter: RTL and testbench
======================================

Name: zcode_event_counter

Overview:
Downstream consumer of the 2-bit detector FSM outputs {z1,z0}. Registers the code every clock and keeps saturating per-code event counts plus a total. Counts are read out over a simple req/ack port with optional clear-on-read. Lets the bench or board logic tally detector hits without watching every cycle.

Parameters:
CNT_W, 8, width of each event counter and of rd_data (min 2)

Ports:
clk  in  1  system clock, all state on posedge
r  in  1  reset, asynchronous, active-low (r=0 resets)
z1  in  1  detector output bit 1 (MSB of code)
z0  in  1  detector output bit 0 (LSB of code)
en  in  1  counting enable; 0 freezes all counters, sampling continues
rd_req  in  1  read request, level, held until rd_ack seen
rd_sel  in  2  counter select: 00 total, 01/10/11 per-code count
rd_clr  in  1  clear selected counter when request accepted
rd_ack  out  1  one-cycle pulse, rd_data valid
rd_data  out  CNT_W  snapshot of selected counter
last_code  out  2  registered {z1,z0}
ovf  out  1  sticky: some increment hit a saturated counter

Behaviour:
- Reset (r=0, async, takes effect without clk): zq, zq_d, all counters, rd_data, rd_ack, ovf = 0; read FSM = IDLE. Release synchronous to next clk edge.
- Input stage: zq <= {z1,z0} every cycle; zq_d <= zq. last_code = zq. Latency z -> last_code 1 cycle.
- Event (default): evt = en && (zq != 2'b00). Edge mode under Optional Feature.
- On evt: cnt[zq] += 1 and cnt_tot += 1, each saturating at 2^CNT_W-1. Attempt to increment a saturated counter sets ovf; ovf cleared only by reset.
- Read FSM, 3 states:
  IDLE: rd_req=1 -> accept: rd_data <= value of cnt[rd_sel] before this cycle's increment; rd_ack <= 1; go ACK.
  ACK: rd_ack=1 exactly this cycle; rd_ack <= 0; rd_req=1 -> WAIT, else IDLE.
  WAIT: stay while rd_req=1; rd_req=0 -> IDLE. No new accept until rd_req seen low.
- Request-to-ack latency: 1 cycle. rd_data holds last snapshot until next accept.
- rd_clr at accept: selected counter cleared same edge. If an increment for that counter occurs same cycle, counter becomes 1 (event not lost; not in snapshot). Clear of sel 00 clears total only; clear of a per-code counter leaves total unchanged.
- rd_sel/rd_clr sampled only at accept; ignored in ACK/WAIT.
- en=0: no increments, reads/clears still work.
- Reset asserted mid-read: rd_ack drops immediately, FSM IDLE.

Optional Feature:
ZCODE_EDGE_ONLY_EN. Defined: evt = en && (zq != 00) && (zq != zq_d); a code held for many cycles counts once, and any change between nonzero codes counts the new code. Undefined: every nonzero cycle counts (default above).

Test Plan:
- Reset: count to cnt1=3, drive r=0 between clk edges -> last_code, rd_ack, ovf, rd_data = 0 before next edge; subsequent reads of all sel return 0.
- Tally: en=1, z=01 x3, 10 x2, 11 x1, 00 -> reads sel1=3, sel2=2, sel3=1, sel0=6; rd_ack high 1 cycle, 1 cycle after rd_req.
- Saturation (CNT_W=4): z=11 for 20 cycles -> sel3 reads 15, sel0 reads 15, ovf=1; ovf stays 1 after clearing reads.
- Clear race: cnt1=5, z=01 held, rd_req with sel=01, rd_clr=1 -> rd_data=5, next read of sel1 (no clr, after z=00) = 1 plus later events; total unaffected.
- Handshake: hold rd_req high 5 cycles -> exactly one rd_ack; en=0 with z toggling -> all counts unchanged.
- Edge mode (macro defined): z=01 x3, 11 x1, 01 x2, 00 -> sel1=2, sel3=1, sel0=3; undefined -> sel1=5, sel3=1, sel0=6.

Source files
------------

// File: rtl/zcode_event_counter_if.sv
// rtl/zcode_event_counter_if.sv - counter read port: level request, one-cycle ack with snapshot data
interface zcode_event_counter_if #(
    parameter int CNT_W = 8
);
    logic             rd_req;
    logic [1:0]       rd_sel;
    logic             rd_clr;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_data;

    modport master (
        output rd_req,
        output rd_sel,
        output rd_clr,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_sel,
        input  rd_clr,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/zcode_event_counter.sv
// rtl/zcode_event_counter.sv - saturating per-code and total tallies of detector codes {z1,z0} with req/ack readout
// Define ZCODE_EDGE_ONLY_EN to count a nonzero code only on the cycle it first appears.
module zcode_event_counter #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  r,
    input  logic                  z1,
    input  logic                  z0,
    input  logic                  en,
    zcode_event_counter_if.slave  rd,
    output logic [1:0]            last_code,
    output logic                  ovf
);
    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

    state_t           state;
    logic [1:0]       zq;
    logic [CNT_W-1:0] cnt     [4];
    logic [CNT_W-1:0] cnt_nxt [4];
    logic [3:0]       hit;
    logic             evt;
    logic             accept;
    logic             ovf_set;

`ifdef ZCODE_EDGE_ONLY_EN
    logic [1:0]       zq_d;

    always_ff @(posedge clk or negedge r) begin
        if (!r) zq_d <= 2'b00;
        else    zq_d <= zq;
    end

    assign evt = en && (zq != 2'b00) && (zq != zq_d);
`else
    assign evt = en && (zq != 2'b00);
`endif

    assign accept    = (state == S_IDLE) && rd.rd_req;
    assign last_code = zq;

    // Slot 0 is the total; slots 1..3 are indexed directly by the registered code.
    always_comb begin
        hit     = 4'b0000;
        ovf_set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hit[i]     = evt && ((i == 0) || (zq == 2'(i)));
            cnt_nxt[i] = cnt[i];
            if (hit[i]) begin
                if (&cnt[i]) ovf_set    = 1'b1;
                else         cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
            // A clear racing an increment keeps the new event.
            if (accept && rd.rd_clr && (rd.rd_sel == 2'(i)))
                cnt_nxt[i] = hit[i] ? CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            zq         <= 2'b00;
            ovf        <= 1'b0;
            state      <= S_IDLE;
            rd.rd_ack  <= 1'b0;
            rd.rd_data <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            zq  <= {z1, z0};
            ovf <= ovf | ovf_set;
            for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
            case (state)
                S_IDLE: begin
                    rd.rd_ack <= 1'b0;
                    if (rd.rd_req) begin
                        rd.rd_data <= cnt[rd.rd_sel];
                        rd.rd_ack  <= 1'b1;
                        state      <= S_ACK;
                    end
                end
                S_ACK: begin
                    rd.rd_ack <= 1'b0;
                    state     <= rd.rd_req ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    rd.rd_ack <= 1'b0;
                    if (!rd.rd_req) state <= S_IDLE;
                end
                default: begin
                    rd.rd_ack <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zcode_event_counter.sv
// tb/tb_zcode_event_counter.sv - directed plus randomized bench for zcode_event_counter against a tally model
module tb_zcode_event_counter;
    localparam int CNT_W = 4;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       r   = 1'b0;
    logic       z1  = 1'b0;
    logic       z0  = 1'b0;
    logic       en  = 1'b1;
    logic [1:0] last_code;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    zcode_event_counter_if #(.CNT_W(CNT_W)) bus ();

    zcode_event_counter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .r         (r),
        .z1        (z1),
        .z0        (z0),
        .en        (en),
        .rd        (bus.slave),
        .last_code (last_code),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference tallies: m_cnt[0] is the total, m_cnt[c] the count for code c.
    int m_cnt [4];
    int m_zq, m_zqd, m_data;
    bit m_busy, m_ack, m_ovf;

    always @(posedge clk or negedge r) begin : model
        int code;
        int nc [4];
        bit evt, acc;
        if (!r) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_zq = 0; m_zqd = 0; m_data = 0;
            m_busy = 0; m_ack = 0; m_ovf = 0;
        end else begin
            code = m_zq;
            evt  = en && (code != 0);
`ifdef ZCODE_EDGE_ONLY_EN
            evt  = evt && (code != m_zqd);
`endif
            acc = bus.rd_req && !m_busy;
            nc  = m_cnt;
            if (evt) begin
                for (int k = 0; k < 2; k++) begin
                    int idx;
                    idx = (k == 0) ? 0 : code;
                    if (m_cnt[idx] == MAX) m_ovf = 1;
                    else nc[idx] = m_cnt[idx] + 1;
                end
            end
            if (acc) begin
                m_data = m_cnt[bus.rd_sel];
                if (bus.rd_clr)
                    nc[bus.rd_sel] = (evt && (bus.rd_sel == 0 || int'(bus.rd_sel) == code)) ? 1 : 0;
            end
            m_ack = acc;
            if (acc) m_busy = 1;
            else if (!bus.rd_req) m_busy = 0;
            m_cnt = nc;
            m_zqd = m_zq;
            m_zq  = {z1, z0};
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("last_code", int'(last_code), m_zq);
        check("rd_ack", int'(bus.rd_ack), int'(m_ack));
        check("ovf", int'(ovf), int'(m_ovf));
        check("rd_data", int'(bus.rd_data), m_data);
    end

    task automatic zdrive(input int z, input int n);
        {z1, z0} = 2'(z);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input int sel, input bit clr, output int data);
        int waited;
        waited     = 0;
        bus.rd_sel = 2'(sel);
        bus.rd_clr = clr;
        bus.rd_req = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.rd_ack && waited < 4);
        check("rd_latency", waited, 1);
        data       = int'(bus.rd_data);
        bus.rd_req = 1'b0;
        bus.rd_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_read(input string name, input int sel, input bit clr, input int exp);
        int d;
        do_read(sel, clr, d);
        check(name, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, d;
        bus.rd_req = 1'b0;
        bus.rd_sel = 2'b00;
        bus.rd_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ack", int'(bus.rd_ack), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_data", int'(bus.rd_data), 0);
        r = 1'b1;
        @(negedge clk);

        zdrive(1, 3); zdrive(2, 2); zdrive(3, 1); zdrive(0, 2);
`ifdef ZCODE_EDGE_ONLY_EN
        expect_read("tally_sel1", 1, 1, 1);
        expect_read("tally_sel2", 2, 1, 1);
        expect_read("tally_sel3", 3, 1, 1);
        expect_read("tally_sel0", 0, 1, 3);
`else
        expect_read("tally_sel1", 1, 1, 3);
        expect_read("tally_sel2", 2, 1, 2);
        expect_read("tally_sel3", 3, 1, 1);
        expect_read("tally_sel0", 0, 1, 6);
`endif

        zdrive(1, 3); zdrive(3, 1); zdrive(1, 2); zdrive(0, 2);
`ifdef ZCODE_EDGE_ONLY_EN
        expect_read("mode_sel1", 1, 1, 2);
        expect_read("mode_sel3", 3, 1, 1);
        expect_read("mode_sel0", 0, 1, 3);
`else
        expect_read("mode_sel1", 1, 1, 5);
        expect_read("mode_sel3", 3, 1, 1);
        expect_read("mode_sel0", 0, 1, 6);
`endif

        for (int i = 0; i < 5; i++) begin zdrive(1, 1); zdrive(0, 1); end
        zdrive(1, 1);
        {z1, z0} = 2'b00;
        expect_read("race_snapshot", 1, 1, 5);
        zdrive(0, 2);
        expect_read("race_after", 1, 0, 1);
        expect_read("race_total", 0, 0, 6);

        bus.rd_sel = 2'd1;
        bus.rd_req = 1'b1;
        acks = 0;
        repeat (5) begin @(negedge clk); acks += int'(bus.rd_ack); end
        bus.rd_req = 1'b0;
        @(negedge clk);
        check("held_req_acks", acks, 1);

        en = 1'b0;
        repeat (12) zdrive(int'($urandom_range(0, 3)), 1);
        zdrive(0, 2);
        en = 1'b1;
        expect_read("frozen_sel1", 1, 1, 1);
        expect_read("frozen_sel2", 2, 1, 0);
        expect_read("frozen_sel3", 3, 1, 0);
        expect_read("frozen_sel0", 0, 1, 6);

        for (int i = 0; i < 20; i++) begin zdrive(3, 1); zdrive(0, 1); end
        zdrive(0, 1);
        check("sat_ovf", int'(ovf), 1);
        expect_read("sat_sel3", 3, 1, MAX);
        expect_read("sat_sel0", 0, 1, MAX);
        expect_read("sat_cleared", 3, 0, 0);
        check("sat_ovf_sticky", int'(ovf), 1);

        for (int i = 0; i < 3; i++) begin zdrive(1, 1); zdrive(0, 1); end
        zdrive(0, 1);
        bus.rd_sel = 2'd1;
        bus.rd_req = 1'b1;
        @(posedge clk);
        #2;
        check("midread_ack", int'(bus.rd_ack), 1);
        check("midread_data", int'(bus.rd_data), 3);
        r = 1'b0;
        #1;
        check("async_ack", int'(bus.rd_ack), 0);
        check("async_ovf", int'(ovf), 0);
        check("async_data", int'(bus.rd_data), 0);
        check("async_code", int'(last_code), 0);
        bus.rd_req = 1'b0;
        @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) expect_read("post_reset", s, 0, 0);

        for (int i = 0; i < 400; i++) begin
            {z1, z0} = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0)
                do_read(int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), d);
            else
                @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
